ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 167 ++++++++++++++++
 tb/tb_ifu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit.
// Issues word-aligned fetch requests to instruction memory under a 2-credit
// rule (outstanding + buffered <= 2). It buffers returned words together with
// their fetch addresses in a 2-entry FIFO and presents the FIFO head to decode.
// A redirect flushes the buffer. Responses still in flight are counted as
// discards, and the DRAIN state drops them before fetching resumes.
//
// Optional build macro: IFU_BYPASS_EN. When it is defined, a response that
// arrives while the FIFO is empty is presented combinationally in the same cycle.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   jump_en_i, jump_addr_i       redirect request and target
//   hold_i                       decode stall
//   imem_req_o, imem_addr_o      fetch request / address
//   imem_gnt_i                   request accepted
//   imem_rvalid_i, imem_rdata_i  in-order read response
//   inst_o, inst_addr_o          instruction and its address
//   inst_valid_o                 instruction outputs are real
//
// state | meaning
// BOOT  | first cycle after reset, no requests
// FETCH | normal fetching under credit limit
// DRAIN | dropping responses issued before a redirect
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

   state_t      state, state_next;
   logic [31:0] pc;

   // granted-address FIFO: one entry per live (non-discarded) outstanding request
   logic [31:0] ab_mem [2];
   logic        ab_rd, ab_wr;
   logic [1:0]  ab_cnt;

   // instruction FIFO
   logic [31:0] ib_data [2];
   logic [31:0] ib_addr [2];
   logic        ib_rd, ib_wr;
   logic [1:0]  ib_cnt;

   logic [1:0]  disc_cnt, disc_next;
   logic [2:0]  used, pend;
   logic        grant, resp_live, resp_drop, byp, pop, pop_ib, push_ib;

   assign used  = {1'b0, ab_cnt} + {1'b0, disc_cnt} + {1'b0, ib_cnt};
   assign pend  = {1'b0, ab_cnt} + {1'b0, disc_cnt};

   assign imem_req_o  = (state == FETCH) && (used < 3'd2) && !jump_en_i;
   assign imem_addr_o = pc;
   assign grant       = imem_req_o & imem_gnt_i;

   // Discards are always older than any live request, so while the discard
   // count is non-zero every response belongs to a discarded request.
   assign resp_drop = imem_rvalid_i && (disc_cnt != 2'd0);
   assign resp_live = imem_rvalid_i && (disc_cnt == 2'd0) && (ab_cnt != 2'd0) && !jump_en_i;

`ifdef IFU_BYPASS_EN
   assign byp = resp_live && (ib_cnt == 2'd0);
`else
   assign byp = 1'b0;
`endif

   always_comb begin
      inst_o       = NOP;
      inst_addr_o  = 32'h0;
      inst_valid_o = 1'b0;
      if (ib_cnt != 2'd0) begin
         inst_o       = ib_data[ib_rd];
         inst_addr_o  = ib_addr[ib_rd];
         inst_valid_o = 1'b1;
      end else if (byp) begin
         inst_o       = imem_rdata_i;
         inst_addr_o  = ab_mem[ab_rd];
         inst_valid_o = 1'b1;
      end
   end

   assign pop     = inst_valid_o && !hold_i && !jump_en_i;
   assign pop_ib  = pop && (ib_cnt != 2'd0);
   // a bypassed word consumed this cycle never enters the FIFO
   assign push_ib = resp_live && !(byp && !hold_i);

   always_comb begin
      disc_next = disc_cnt;
      if (jump_en_i) begin
         // every in-flight request becomes a discard, minus one returning now
         disc_next = pend[1:0] - {1'b0, (imem_rvalid_i && (pend != 3'd0))};
      end else if (resp_drop) begin
         disc_next = disc_cnt - 2'd1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = FETCH;
         FETCH:   if (jump_en_i && (disc_next != 2'd0)) state_next = DRAIN;
         DRAIN:   if (disc_next == 2'd0) state_next = FETCH;
         default: state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         disc_cnt <= 2'd0;
         ab_rd    <= 1'b0;
         ab_wr    <= 1'b0;
         ab_cnt   <= 2'd0;
         ib_rd    <= 1'b0;
         ib_wr    <= 1'b0;
         ib_cnt   <= 2'd0;
      end else begin
         state    <= state_next;
         disc_cnt <= disc_next;
         if (jump_en_i) begin
            pc     <= {jump_addr_i[31:2], 2'b00};
            ab_rd  <= 1'b0;
            ab_wr  <= 1'b0;
            ab_cnt <= 2'd0;
            ib_rd  <= 1'b0;
            ib_wr  <= 1'b0;
            ib_cnt <= 2'd0;
         end else begin
            if (grant) begin
               pc    <= pc + 32'd4;
               ab_wr <= ~ab_wr;
            end
            if (resp_live) ab_rd <= ~ab_rd;
            ab_cnt <= ab_cnt + {1'b0, grant} - {1'b0, resp_live};
            if (push_ib) ib_wr <= ~ib_wr;
            if (pop_ib)  ib_rd <= ~ib_rd;
            ib_cnt <= ib_cnt + {1'b0, push_ib} - {1'b0, pop_ib};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant) ab_mem[ab_wr] <= pc;
      if (push_ib && !jump_en_i) begin
         ib_data[ib_wr] <= imem_rdata_i;
         ib_addr[ib_wr] <= ab_mem[ab_rd];
      end
   end

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] TAG = 32'hA000_0000;

   int checks = 0;
   int failures = 0;

   logic [31:0] q[$];
   bit          resp_en;

   ifu dut (
      .clk(clk), .rst(rst),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hold;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_iaddr;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: grants whatever imem_gnt_i allows, answers in order one
   // cycle after grant when resp_en is set; data = address | TAG.
   task automatic tick();
      bit          g;
      bit          rv;
      logic [31:0] ga;
      g  = imem_req_o & imem_gnt_i;
      ga = imem_addr_o;
      rv = imem_rvalid_i;
      @(posedge clk);
      #1;
      if (rv && q.size() > 0) void'(q.pop_front());
      if (g) q.push_back(ga);
      if (resp_en && q.size() > 0) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = q[0] | TAG;
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = 32'h0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      resp_en = 1'b1;
      q.delete();
      #1;
      check("rst_req", {31'h0, imem_req_o}, 32'h0);
      check("rst_inst", inst_o, NOP);
      @(posedge clk);
      #1;
      rst = 1'b0;
      imem_gnt_i = 1'b1;
      #2;
      check("boot_req", {31'h0, imem_req_o}, 32'h0);
      check("boot_addr", imem_addr_o, 32'h0);
      check("boot_valid", {31'h0, inst_valid_o}, 32'h0);
      tick();
   endtask

   task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                          input logic valid, input logic [31:0] iaddr, input logic [31:0] inst);
      check({tag, "_req"}, {31'h0, imem_req_o}, {31'h0, req});
      if (req) check({tag, "_addr"}, imem_addr_o, addr);
      check({tag, "_valid"}, {31'h0, inst_valid_o}, {31'h0, valid});
      check({tag, "_iaddr"}, inst_addr_o, iaddr);
      check({tag, "_inst"}, inst_o, inst);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  NOP};
      vecs[1] = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0,  NOP};
      vecs[2] = '{1'b0, 1'b0, 32'd8,  1'b1, 32'd0,  TAG | 32'd0};
      vecs[3] = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd4,  TAG | 32'd4};
      vecs[4] = '{1'b0, 1'b1, 32'd12, 1'b0, 32'd0,  NOP};
      vecs[5] = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd8,  TAG | 32'd8};
      vecs[6] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd12, TAG | 32'd12};

      // streaming fetch, grant every cycle, 1-cycle response
      do_reset();
      for (int i = 0; i < 7; i++) begin
         hold_i = vecs[i].hold;
         #2;
         chk_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                 vecs[i].exp_valid, vecs[i].exp_iaddr, vecs[i].exp_inst);
         tick();
      end

      // hold for 5 cycles with two fetches granted
      do_reset();
      hold_i = 1'b1;
      #2; tick();                                    // C0 grant 0
      #2; tick();                                    // C1 grant 4
      for (int i = 2; i < 5; i++) begin
         #2;
         chk_out($sformatf("hold%0d", i), 1'b0, 32'd8, 1'b1, 32'd0, TAG | 32'd0);
         tick();
      end
      hold_i = 1'b0;
      #2;
      chk_out("hold_rel", 1'b0, 32'd8, 1'b1, 32'd0, TAG | 32'd0);
      tick();
      #2;
      chk_out("hold_next", 1'b1, 32'd8, 1'b1, 32'd4, TAG | 32'd4);
      tick();
      #2;
      check("hold_empty", {31'h0, inst_valid_o}, 32'h0);

      // redirect with two outstanding responses
      do_reset();
      resp_en = 1'b0;
      #2; tick();
      #2; tick();
      jump_en_i = 1'b1; jump_addr_i = 32'h100;
      #2;
      check("jmp_req", {31'h0, imem_req_o}, 32'h0);
      tick();
      jump_en_i = 1'b0;
      #2;
      chk_out("drain0", 1'b0, 32'h100, 1'b0, 32'h0, NOP);
      resp_en = 1'b1;
      tick();
      #2; chk_out("drain1", 1'b0, 32'h100, 1'b0, 32'h0, NOP); tick();
      #2; chk_out("drain2", 1'b0, 32'h100, 1'b0, 32'h0, NOP); tick();
      #2; chk_out("refetch", 1'b1, 32'h100, 1'b0, 32'h0, NOP); tick();
      #2; chk_out("refetch1", 1'b1, 32'h104, 1'b0, 32'h0, NOP); tick();
      #2; chk_out("jmp_out", 1'b0, 32'h108, 1'b1, 32'h100, TAG | 32'h100);

      // unaligned jump target
      do_reset();
      jump_en_i = 1'b1; jump_addr_i = 32'h203;
      #2; tick();
      jump_en_i = 1'b0;
      #2;
      chk_out("align", 1'b1, 32'h200, 1'b0, 32'h0, NOP);

      // pc wrap
      do_reset();
      jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
      #2; tick();
      jump_en_i = 1'b0;
      #2;
      check("wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
      tick();
      #2;
      check("wrap_addr", imem_addr_o, 32'h0000_0000);

      // reset with one request outstanding, stale response afterwards
      do_reset();
      resp_en = 1'b0;
      #2; tick();
      rst = 1'b1;
      #1;
      chk_out("mid_rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      check("mid_rst_addr", imem_addr_o, 32'h0);
      q.delete();
      imem_rvalid_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      resp_en = 1'b1;
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
      #2;
      chk_out("late_boot", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      tick();
      #2;
      chk_out("late_c0", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      tick();
      #2; tick();
      #2;
      chk_out("late_c2", 1'b0, 32'h8, 1'b1, 32'h0, TAG | 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
